bus_interface: RTL and testbench



---
 rtl/bus_interface.sv | 218 +++++++++++++++++++++
 tb/tb_bus_interface.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_interface.sv
// Single-master CPU-to-memory bus bridge: big-endian lane steering, read extraction, optional wait states.
// Define BUS_MISALIGN_CHECK_EN to reject misaligned or reserved-size requests with cpu_bus_error.
module bus_interface #(
   parameter int WAIT_STATES = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_write,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_signed,
   input  logic [31:0] cpu_address,
   input  logic [31:0] cpu_data_in,
   output logic [31:0] cpu_data_out,
   output logic        cpu_ack,
   output logic        cpu_bus_error,
   output logic        mem_cs,
   output logic        mem_read,
   output logic        mem_write,
   output logic [29:0] mem_address,
   output logic [3:0]  mem_data_strobes,
   output logic [31:0] mem_data_out,
   input  logic [31:0] mem_data_in
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAccess = 2'd1;
   localparam logic [1:0] StDone   = 2'd2;

   localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

   logic [1:0]  state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [1:0]  offset_q, offset_d;
   logic        cs_q, cs_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [29:0] addr_q, addr_d;
   logic [3:0]  strb_q, strb_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ack_q, ack_d;
`ifdef BUS_MISALIGN_CHECK_EN
   logic        err_q, err_d;
`endif

   logic [1:0]  reqSize;
   logic        reqLegal;
   logic [3:0]  reqStrobes;
   logic [31:0] reqWdata;
   logic [31:0] laneShifted;
   logic [7:0]  readByte;
   logic [15:0] readHalf;
   logic [31:0] readAligned;

   // Decode the incoming request; reserved size 11 behaves as a word when it is not rejected.
   always_comb begin
      reqSize = (cpu_size == 2'b11) ? 2'b10 : cpu_size;
`ifdef BUS_MISALIGN_CHECK_EN
      reqLegal = !((cpu_size == 2'b11) ||
                   (cpu_size == 2'b01 && cpu_address[0]) ||
                   (cpu_size == 2'b10 && cpu_address[1:0] != 2'b00));
`else
      reqLegal = 1'b1;
`endif
      case (reqSize)
         2'b00: begin
            reqStrobes = 4'b1000 >> cpu_address[1:0];
            reqWdata   = {4{cpu_data_in[7:0]}};
         end
         2'b01: begin
            reqStrobes = cpu_address[1] ? 4'b0011 : 4'b1100;
            reqWdata   = {2{cpu_data_in[15:0]}};
         end
         default: begin
            reqStrobes = 4'b1111;
            reqWdata   = cpu_data_in;
         end
      endcase
   end

   // Big-endian: offset 0 lives in lane 3, so the byte shift is 8 * (3 - offset).
   always_comb begin
      laneShifted = mem_data_in >> {~offset_q, 3'b000};
      readByte    = laneShifted[7:0];
      readHalf    = offset_q[1] ? mem_data_in[15:0] : mem_data_in[31:16];
      case (size_q)
         2'b00:   readAligned = {{24{signed_q & readByte[7]}}, readByte};
         2'b01:   readAligned = {{16{signed_q & readHalf[15]}}, readHalf};
         default: readAligned = mem_data_in;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      write_d  = write_q;
      size_d   = size_q;
      signed_d = signed_q;
      offset_d = offset_q;
      cs_d     = cs_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      strb_d   = strb_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      ack_d    = 1'b0;
`ifdef BUS_MISALIGN_CHECK_EN
      err_d    = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (cpu_req) begin
               write_d  = cpu_write;
               size_d   = reqSize;
               signed_d = cpu_signed;
               offset_d = cpu_address[1:0];
               if (reqLegal) begin
                  state_d = StAccess;
                  wait_d  = WaitLoad;
                  cs_d    = 1'b1;
                  rd_d    = !cpu_write;
                  wr_d    = cpu_write;
                  addr_d  = cpu_address[31:2];
                  strb_d  = reqStrobes;
                  wdata_d = reqWdata;
               end else begin
                  // Rejected requests go straight to the ack cycle without touching memory.
                  state_d = StDone;
                  ack_d   = 1'b1;
`ifdef BUS_MISALIGN_CHECK_EN
                  err_d   = 1'b1;
`endif
               end
            end
         end
         StAccess: begin
            if (wait_q == 4'd0) begin
               state_d = StDone;
               ack_d   = 1'b1;
               cs_d    = 1'b0;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               if (!write_q) begin
                  rdata_d = readAligned;
               end
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         wait_q   <= 4'd0;
         write_q  <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         offset_q <= 2'b00;
         cs_q     <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= 30'd0;
         strb_q   <= 4'b0000;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         ack_q    <= 1'b0;
`ifdef BUS_MISALIGN_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         write_q  <= write_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         offset_q <= offset_d;
         cs_q     <= cs_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         strb_q   <= strb_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
`ifdef BUS_MISALIGN_CHECK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign cpu_data_out     = rdata_q;
   assign cpu_ack          = ack_q;
   assign mem_cs           = cs_q;
   assign mem_read         = rd_q;
   assign mem_write        = wr_q;
   assign mem_address      = addr_q;
   assign mem_data_strobes = strb_q;
   assign mem_data_out     = wdata_q;
`ifdef BUS_MISALIGN_CHECK_EN
   assign cpu_bus_error    = err_q;
`else
   assign cpu_bus_error    = 1'b0;
`endif

endmodule

// File: tb/tb_bus_interface.sv
// Testbench for bus_interface: directed and random accesses against a byte-addressed big-endian reference model.
// Expectations adapt to whether BUS_MISALIGN_CHECK_EN is defined.
module tb_bus_interface;

   localparam int W = 2;

   logic        clock;
   logic        reset;
   logic        cpu_req;
   logic        cpu_write;
   logic [1:0]  cpu_size;
   logic        cpu_signed;
   logic [31:0] cpu_address;
   logic [31:0] cpu_data_in;
   logic [31:0] cpu_data_out;
   logic        cpu_ack;
   logic        cpu_bus_error;
   logic        mem_cs;
   logic        mem_read;
   logic        mem_write;
   logic [29:0] mem_address;
   logic [3:0]  mem_data_strobes;
   logic [31:0] mem_data_out;
   logic [31:0] mem_data_in = 32'd0;

   bus_interface #(.WAIT_STATES(W)) dut (
      .clock(clock),
      .reset(reset),
      .cpu_req(cpu_req),
      .cpu_write(cpu_write),
      .cpu_size(cpu_size),
      .cpu_signed(cpu_signed),
      .cpu_address(cpu_address),
      .cpu_data_in(cpu_data_in),
      .cpu_data_out(cpu_data_out),
      .cpu_ack(cpu_ack),
      .cpu_bus_error(cpu_bus_error),
      .mem_cs(mem_cs),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_address(mem_address),
      .mem_data_strobes(mem_data_strobes),
      .mem_data_out(mem_data_out),
      .mem_data_in(mem_data_in)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Word-organised memory that reacts on the falling edge inside access cycles.
   logic [31:0] memWords [16] = '{default: 32'd0};
   logic [31:0] memTemp;
   always @(negedge clock) begin
      if (mem_cs) begin
         if (mem_write) begin
            memTemp = memWords[mem_address[3:0]];
            for (int l = 0; l < 4; l++) begin
               if (mem_data_strobes[l]) memTemp[8*l +: 8] = mem_data_out[8*l +: 8];
            end
            memWords[mem_address[3:0]] <= memTemp;
         end
         if (mem_read) mem_data_in <= memWords[mem_address[3:0]];
      end
   end

   logic [7:0]  refBytes [64];
   logic [31:0] expDataOut;
   int testsRun  = 0;
   int failCount = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int nBytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit isLegal(input logic [1:0] sz, input logic [31:0] addr);
`ifdef BUS_MISALIGN_CHECK_EN
      return !((sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00));
`else
      return (sz == sz) && (addr == addr);
`endif
   endfunction

   function automatic logic [31:0] modelRead(input int base, input int n, input logic sgn);
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(refBytes[base + i]);
      if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   // One complete transaction; the request is held and its fields scrambled while the access is in flight.
   task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] sz, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
      int n, base, lat, csCycles;
      bit legal;
      logic [3:0]  expStrb, gotStrb;
      logic [31:0] expMd, gotMd;
      logic [29:0] gotAddr;
      logic [1:0]  gotRw;
      logic        gotErr;
      n = nBytes(sz);
      base = int'(addr[5:0]) & ~(n - 1);
      legal = isLegal(sz, addr);
      expStrb = 4'b0000;
      for (int i = 0; i < n; i++) expStrb[3 - ((base + i) % 4)] = 1'b1;
      expMd = (n == 1) ? {4{wdata[7:0]}} : (n == 2) ? {2{wdata[15:0]}} : wdata;

      @(negedge clock);
      cpu_req = 1'b1; cpu_write = wr; cpu_size = sz; cpu_signed = sgn;
      cpu_address = addr; cpu_data_in = wdata;
      @(posedge clock); #1;
      lat = 0; csCycles = 0; gotStrb = 4'b0; gotMd = 32'd0; gotAddr = 30'd0; gotRw = 2'b00;
      while (cpu_ack !== 1'b1 && lat < 40) begin
         if (mem_cs === 1'b1) begin
            csCycles++;
            gotStrb = mem_data_strobes; gotMd = mem_data_out;
            gotAddr = mem_address;      gotRw = {mem_read, mem_write};
         end
         @(negedge clock);
         cpu_write = 1'($urandom); cpu_size = 2'($urandom); cpu_signed = 1'($urandom);
         cpu_address = $urandom; cpu_data_in = $urandom;
         @(posedge clock); #1;
         lat++;
      end
      gotErr = cpu_bus_error;
      checkOutput({tag, ":latency"}, 32'(lat), legal ? 32'(1 + W) : 32'd0);
      checkOutput({tag, ":csCycles"}, 32'(csCycles), legal ? 32'(1 + W) : 32'd0);
      checkOutput({tag, ":busError"}, 32'(gotErr), legal ? 32'd0 : 32'd1);
      if (legal) begin
         checkOutput({tag, ":strobes"}, 32'(gotStrb), 32'(expStrb));
         checkOutput({tag, ":memAddress"}, 32'(gotAddr), {2'b00, addr[31:2]});
         checkOutput({tag, ":readWrite"}, 32'(gotRw), {30'd0, !wr, wr});
         if (wr) begin
            checkOutput({tag, ":memDataOut"}, gotMd, expMd);
            for (int i = 0; i < n; i++) refBytes[base + i] = 8'(wdata >> (8 * (n - 1 - i)));
         end else begin
            expDataOut = modelRead(base, n, sgn);
         end
      end
      checkOutput({tag, ":cpuDataOut"}, cpu_data_out, expDataOut);
      @(negedge clock);
      cpu_req = 1'b0;
      @(posedge clock); #1;
      checkOutput({tag, ":ackPulse"}, 32'(cpu_ack), 32'd0);
      @(posedge clock); #1;
      checkOutput({tag, ":noRetrigger"}, 32'(mem_cs), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) refBytes[i] = 8'd0;
      expDataOut = 32'd0;
      reset = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_size = 2'b00;
      cpu_signed = 1'b0; cpu_address = 32'd0; cpu_data_in = 32'd0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset:cs", 32'(mem_cs), 32'd0);
      checkOutput("reset:ack", 32'(cpu_ack), 32'd0);
      checkOutput("reset:strobes", 32'(mem_data_strobes), 32'd0);
      checkOutput("reset:memAddress", 32'(mem_address), 32'd0);
      checkOutput("reset:cpuDataOut", cpu_data_out, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      applyStimulus("wordWrite10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      applyStimulus("wordRead10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      applyStimulus("byteWrite13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080);
      applyStimulus("byteReadS13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
      applyStimulus("byteReadU13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      applyStimulus("wordWrite20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hAABBCCDD);
      applyStimulus("halfWrite22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_1234);
      applyStimulus("wordRead20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      applyStimulus("halfReadS20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
      applyStimulus("wordRead02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
      applyStimulus("size11Read", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);

      // Reset lands in the second access cycle of a read.
      @(negedge clock);
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_size = 2'b10; cpu_address = 32'h10;
      @(posedge clock); #1;
      @(negedge clock);
      cpu_req = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      checkOutput("midReset:controls", {27'd0, mem_cs, mem_read, mem_write, cpu_ack, cpu_bus_error}, 32'd0);
      checkOutput("midReset:strobes", 32'(mem_data_strobes), 32'd0);
      checkOutput("midReset:memAddress", 32'(mem_address), 32'd0);
      checkOutput("midReset:memDataOut", mem_data_out, 32'd0);
      checkOutput("midReset:cpuDataOut", cpu_data_out, 32'd0);
      expDataOut = 32'd0;
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("midReset:noAck", 32'(cpu_ack), 32'd0);
      applyStimulus("afterReset", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

      for (int k = 0; k < 40; k++) begin
         applyStimulus($sformatf("rand%0d", k), 1'($urandom), 2'($urandom), 1'($urandom),
                       32'($urandom_range(0, 63)), $urandom);
      end
      for (int k = 0; k < 16; k++) begin
         applyStimulus($sformatf("sweep%0d", k), 1'b0, 2'b10, 1'b0, 32'(4 * k), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
